payload_match_reporter: RTL and testbench
=========================================

# payload_match_reporter

Collects the sticky match flags from a bank of payload engines at the end of each payload. It serialises the set flags into rule-ID records on a valid/ready stream for the alert/statistics logic. It sits directly behind the engine array, on the read side of the engines' `out` lines, and shares the engines' `sod`/`en` byte-stream qualifiers.

## Interface
Parameters:
- `NUM_ENGINES`, default 64: number of engine match flags; range 2–256.
- `ID_W`, default 6: rule-ID width; equals ceil(log2(`NUM_ENGINES`)).
- `PKT_W`, default 16: width of the packet sequence number.

Ports:
- `clk`, input, 1: single clock for the block.
- `resetn`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: byte-valid qualifier, the same signal the engines receive.
- `sod`, input, 1: start of data, the same signal the engines use as their clear.
- `eod`, input, 1: end of data; asserted with `en` on the last payload byte.
- `match_in`, input, `NUM_ENGINES`: engine `out` flags; bit i is engine i.
- `rpt_valid`, output, 1: a report record is present.
- `rpt_ready`, input, 1: the downstream consumer accepts the record.
- `rpt_id`, output, `ID_W`: index of the matching engine.
- `rpt_none`, output, 1: the record means "no match in this packet"; `rpt_id` is 0 in that case.
- `rpt_last`, output, 1: final record for the packet.
- `rpt_pkt`, output, `PKT_W`: sequence number of the packet being reported.
- `busy`, output, 1: the reporter is not in IDLE.
- `drop_cnt`, output, 16: count of `eod` events lost while busy; saturates at 0xFFFF.

## Operation
- FSM states: IDLE, SETTLE, SCAN.
- **IDLE:** `eod & en` moves the FSM to SETTLE.
- **SETTLE, one cycle:** engine flags are registered one cycle after the last byte. This cycle copies `match_in` into the pending vector `pend`, then moves to SCAN.
- **SCAN:** `rpt_id` is the lowest set index of `pend`.
  - `rpt_last` = 1 when at most one bit of `pend` is set.
  - If `pend` is all zero, one record is presented with `rpt_none`=1, `rpt_last`=1, `rpt_id`=0.
  - On each handshake (`rpt_valid & rpt_ready`), the reported bit of `pend` is cleared.
  - On the handshake of the `rpt_last` record, the FSM returns to IDLE and `rpt_pkt` increments.
- **Back-to-back packets:** an `eod & en` arriving in the same cycle as the final handshake is accepted. The FSM goes straight to SETTLE and no packet is lost.
- **`eod & en` in SETTLE, or in SCAN without the final handshake:** the packet is dropped and `drop_cnt` increments (saturating). The snapshot in progress is unaffected.
- **`sod` during SETTLE or SCAN:** no effect on `pend` or the FSM. Only the engines are cleared.
- `match_in` outside the SETTLE cycle is ignored.
- **`rpt_pkt`:** counts packets fully reported, modulo 2^`PKT_W`; wraps from 0xFFFF to 0x0000. Dropped packets do not advance it.
- **Asynchronous reset:** any state goes to IDLE and `pend` clears. A record in flight is abandoned and never completed.

## Timing
- Reset values:
  - `rpt_valid` = 0, `rpt_id` = 0, `rpt_none` = 0, `rpt_last` = 0.
  - `rpt_pkt` = 0, `busy` = 0, `drop_cnt` = 0.
- Latency: `eod & en` in cycle N → SETTLE in N+1 → first `rpt_valid` in N+2.
- One record per cycle while `rpt_ready` stays high. A packet with k matches takes k cycles in SCAN, or 1 cycle if k = 0.
- Once `rpt_valid` is raised, it and `rpt_id`, `rpt_none`, `rpt_last`, `rpt_pkt` stay stable until the handshake.
- `rpt_valid` never depends combinationally on `rpt_ready`.
- `busy` = 1 in SETTLE and SCAN. It is registered and reflects the state of the current cycle.
- The lowest-set-bit search is a combinational priority encoder over `NUM_ENGINES` bits. Outputs are registered from `pend` and the FSM state.

## Test plan
- **Single match:** `match_in` = bit 5 at SETTLE, `rpt_ready`=1 → one record at N+2 with `rpt_id`=5, `rpt_last`=1, `rpt_none`=0. `rpt_pkt`=0 during the record, then 1.
- **Multiple matches with backpressure:** bits {63, 0, 17} set, `rpt_ready` toggled 1/0 → IDs 0, 17, 63 in order, each held stable during stall cycles. `rpt_last` is set only with 63.
- **No match:** `match_in`=0 → one record with `rpt_none`=1, `rpt_id`=0, `rpt_last`=1.
- **Overlap:**
  - Second `eod` during SCAN of a 3-match packet → `drop_cnt`=1; only the first packet is reported.
  - `eod` coincident with the final handshake → second packet reported, `drop_cnt` unchanged.
- **Reset:** `resetn` low mid-SCAN → all outputs return to reset values in the same cycle. The next `eod` reports normally with `rpt_pkt`=0.
- **Wrap:** `rpt_pkt` preloaded via 65535 packets then one more → `rpt_pkt` reads 0xFFFF on the 65536th packet and 0x0000 afterwards.

Source files
------------

// File: rtl/payload_match_reporter.sv
// Serialises the sticky match flags of an engine bank into rule-ID records
// at the end of each payload, one record per accepted valid/ready handshake.
module payload_match_reporter #(
  parameter int NUM_ENGINES = 64,
  parameter int ID_W        = 6,
  parameter int PKT_W       = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic                   sod,
  input  logic                   eod,
  input  logic [NUM_ENGINES-1:0] match_in,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [ID_W-1:0]        rpt_id,
  output logic                   rpt_none,
  output logic                   rpt_last,
  output logic [PKT_W-1:0]       rpt_pkt,
  output logic                   busy,
  output logic [15:0]            drop_cnt,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  state_t                 state_q;
  logic [NUM_ENGINES-1:0] pend_q;
  logic [NUM_ENGINES-1:0] pend_d;
  logic                   rpt_valid_q;
  logic [ID_W-1:0]        rpt_id_q;
  logic                   rpt_none_q;
  logic                   rpt_last_q;
  logic [PKT_W-1:0]       rpt_pkt_q;
  logic                   busy_q;
  logic [15:0]            drop_cnt_q;

  logic                   eod_hit;
  logic                   hs;
  logic                   final_hs;
  logic                   drop_evt;
  logic [ID_W-1:0]        enc_id;
  logic                   enc_none;
  logic                   enc_multi;

  // sod only clears the engines; the snapshot here is never affected by it.
  logic unused_sod;
  assign unused_sod = sod;

  // Stream contract: a record transfers on a cycle where rpt_valid and
  // rpt_ready are both high. rpt_valid and the record fields are registered,
  // never depend on rpt_ready in the same cycle, and hold until the transfer.
  assign eod_hit  = eod & en;
  assign hs       = rpt_valid_q & rpt_ready;
  assign final_hs = hs & rpt_last_q;
  assign drop_evt = eod_hit & ((state_q == ST_SETTLE) ||
                               ((state_q == ST_SCAN) && !final_hs));

  // Pending vector as it will be next cycle: loaded in SETTLE, and the
  // reported bit is cleared on each handshake during SCAN.
  always_comb begin
    pend_d = pend_q;
    case (state_q)
      ST_SETTLE: pend_d = match_in;
      ST_SCAN: begin
        if (hs && !rpt_none_q) begin
          pend_d[rpt_id_q] = 1'b0;
        end
      end
      default: pend_d = pend_q;
    endcase
  end

  // Lowest-set-bit priority encoder over the next pending vector, so the
  // registered record always describes what is still outstanding.
  always_comb begin
    enc_id = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (pend_d[i]) begin
        enc_id = ID_W'(i);
      end
    end
  end

  assign enc_none  = ~|pend_d;
  assign enc_multi = |(pend_d & (pend_d - 1'b1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      rpt_valid_q <= 1'b0;
      rpt_id_q    <= '0;
      rpt_none_q  <= 1'b0;
      rpt_last_q  <= 1'b0;
      rpt_pkt_q   <= '0;
      busy_q      <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;

      if (drop_evt && (drop_cnt_q != DROP_MAX)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (eod_hit) begin
            state_q <= ST_SETTLE;
            busy_q  <= 1'b1;
          end
        end

        ST_SETTLE: begin
          state_q     <= ST_SCAN;
          busy_q      <= 1'b1;
          rpt_valid_q <= 1'b1;
          rpt_id_q    <= enc_id;
          rpt_none_q  <= enc_none;
          rpt_last_q  <= ~enc_multi;
        end

        ST_SCAN: begin
          if (final_hs) begin
            rpt_pkt_q   <= rpt_pkt_q + PKT_W'(1);
            rpt_valid_q <= 1'b0;
            rpt_id_q    <= '0;
            rpt_none_q  <= 1'b0;
            rpt_last_q  <= 1'b0;
            // A new eod on the final handshake starts the next snapshot.
            if (eod_hit) begin
              state_q <= ST_SETTLE;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            rpt_valid_q <= 1'b1;
            rpt_id_q    <= enc_id;
            rpt_none_q  <= enc_none;
            rpt_last_q  <= ~enc_multi;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign rpt_id    = rpt_id_q;
  assign rpt_none  = rpt_none_q;
  assign rpt_last  = rpt_last_q;
  assign rpt_pkt   = rpt_pkt_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_payload_match_reporter.sv
// Bench for payload_match_reporter: drives payload ends with engine flag
// snapshots and checks the record stream against an expected-record queue.
module tb_payload_match_reporter;

  localparam int NE = 64;
  localparam int IW = 6;
  // Narrow packet counter keeps the wrap test short.
  localparam int PW = 10;
  localparam int W  = PW + 2 + IW;

  logic          clk;
  logic          resetn;
  logic          en;
  logic          sod;
  logic          eod;
  logic [NE-1:0] match_in;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [IW-1:0] rpt_id;
  logic          rpt_none;
  logic          rpt_last;
  logic [PW-1:0] rpt_pkt;
  logic          busy;
  logic [15:0]   drop_cnt;
  logic [1:0]    dbg_state;

  payload_match_reporter #(
    .NUM_ENGINES(NE),
    .ID_W       (IW),
    .PKT_W      (PW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .sod      (sod),
    .eod      (eod),
    .match_in (match_in),
    .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready),
    .rpt_id   (rpt_id),
    .rpt_none (rpt_none),
    .rpt_last (rpt_last),
    .rpt_pkt  (rpt_pkt),
    .busy     (busy),
    .drop_cnt (drop_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks;
  int            n_errs;
  logic [W-1:0]  exp_q[$];
  logic [PW-1:0] exp_pkt;
  int            ready_mode; // 0 high, 1 toggle, 2 random, 3 low

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer backpressure pattern.
  initial begin
    rpt_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rpt_ready = 1'b1;
        1:       rpt_ready = ~rpt_ready;
        2:       rpt_ready = 1'($urandom_range(0, 1));
        default: rpt_ready = 1'b0;
      endcase
    end
  end

  // scoreboard: compare each transferred record, and check stalled records hold
  logic         stall_q;
  logic [W-1:0] stall_rec;
  logic [W-1:0] cur_rec;
  always @(negedge clk) begin
    if (!resetn) begin
      stall_q = 1'b0;
    end else begin
      cur_rec = {rpt_pkt, rpt_none, rpt_last, rpt_id};
      if (stall_q) begin
        check("hold_valid", 64'(rpt_valid), 64'd1);
        check("hold_rec", 64'(cur_rec), 64'(stall_rec));
      end
      if (rpt_valid && rpt_ready) begin
        if (exp_q.size() == 0) check("extra_rec", 64'(cur_rec), 64'h0);
        else check("rec", 64'(cur_rec), 64'(exp_q.pop_front()));
      end
      stall_q   = rpt_valid && !rpt_ready;
      stall_rec = cur_rec;
    end
  end

  task automatic push_records(input logic [NE-1:0] mask);
    int left;
    left = $countones(mask);
    if (left == 0) begin
      exp_q.push_back({exp_pkt, 1'b1, 1'b1, IW'(0)});
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (mask[i]) begin
          exp_q.push_back({exp_pkt, 1'b0, (left == 1), IW'(i)});
          left--;
        end
      end
    end
    exp_pkt = exp_pkt + 1'b1;
  endtask

  // eod cycle, then the SETTLE cycle carrying the snapshot, then random noise.
  task automatic start_pkt(input logic [NE-1:0] mask, input bit accept, input bit eod2);
    eod = 1'b1;
    en  = 1'b1;
    tick();
    if (accept) begin
      check("busy_settle", 64'(busy), 64'd1);
      check("valid_settle", 64'(rpt_valid), 64'd0);
    end
    eod      = eod2;
    en       = eod2 ? 1'b1 : 1'($urandom_range(0, 1));
    sod      = 1'($urandom_range(0, 1));
    match_in = mask;
    tick();
    eod      = 1'b0;
    en       = 1'($urandom_range(0, 1));
    sod      = 1'($urandom_range(0, 1));
    match_in = {$urandom, $urandom};
    if (accept) begin
      push_records(mask);
      check("latency_valid", 64'(rpt_valid), 64'd1);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (!busy && exp_q.size() == 0) return;
      tick();
    end
    check("timeout_idle", 64'd1, 64'd0);
  endtask

  task automatic wait_final(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (rpt_valid && rpt_last) return;
      tick();
    end
    check("timeout_final", 64'd1, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(rpt_valid), 64'd0);
    check({tag, "_id"}, 64'(rpt_id), 64'd0);
    check({tag, "_none"}, 64'(rpt_none), 64'd0);
    check({tag, "_last"}, 64'(rpt_last), 64'd0);
    check({tag, "_pkt"}, 64'(rpt_pkt), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_drop"}, 64'(drop_cnt), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NE-1:0] m;
    int n_wrap;
    n_checks   = 0;
    n_errs     = 0;
    exp_pkt    = '0;
    ready_mode = 0;
    resetn     = 1'b0;
    en         = 1'b0;
    sod        = 1'b0;
    eod        = 1'b0;
    match_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    resetn = 1'b1;
    tick();
    tick();

    // eod without en must not start a snapshot
    eod = 1'b1;
    en  = 1'b0;
    tick();
    check("no_en_busy", 64'(busy), 64'd0);
    eod = 1'b0;
    tick();

    // single match
    start_pkt(64'h20, 1'b1, 1'b0);
    wait_idle(50);
    check("pkt_single", 64'(rpt_pkt), 64'(exp_pkt));

    // multiple matches with alternating backpressure
    ready_mode = 1;
    start_pkt(64'h8000_0000_0002_0001, 1'b1, 1'b0);
    wait_idle(100);

    // no match
    ready_mode = 0;
    start_pkt('0, 1'b1, 1'b0);
    wait_idle(50);
    check("pkt_none", 64'(rpt_pkt), 64'(exp_pkt));

    // eod during SCAN is dropped
    ready_mode = 1;
    start_pkt(64'h0000_0100_0000_1008, 1'b1, 1'b0);
    start_pkt({$urandom, $urandom}, 1'b0, 1'b0);
    wait_idle(100);
    check("drop_scan", 64'(drop_cnt), 64'd1);
    check("pkt_drop_scan", 64'(rpt_pkt), 64'(exp_pkt));

    // eod during SETTLE is dropped
    start_pkt(64'h0400_0000_0000_0002, 1'b1, 1'b1);
    wait_idle(100);
    check("drop_settle", 64'(drop_cnt), 64'd2);
    check("pkt_drop_settle", 64'(rpt_pkt), 64'(exp_pkt));

    // eod coincident with the final handshake is accepted
    ready_mode = 0;
    tick();
    tick();
    start_pkt(64'h0000_0000_8000_0040, 1'b1, 1'b0);
    wait_final(20);
    start_pkt(64'h1000_0000_0000_0000, 1'b1, 1'b0);
    wait_idle(50);
    check("drop_b2b", 64'(drop_cnt), 64'd2);
    check("pkt_b2b", 64'(rpt_pkt), 64'(exp_pkt));

    // random snapshots under random backpressure
    ready_mode = 2;
    for (int p = 0; p < 20; p++) begin
      m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) m = '0;
      start_pkt(m, 1'b1, 1'b0);
      wait_idle(400);
    end
    check("pkt_random", 64'(rpt_pkt), 64'(exp_pkt));

    // reset in the middle of a stalled SCAN abandons the record
    ready_mode = 3;
    start_pkt(64'h0000_0003_0000_0100, 1'b1, 1'b0);
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check_reset_outputs("midscan");
    exp_q.delete();
    exp_pkt = '0;
    tick();
    resetn = 1'b1;
    ready_mode = 0;
    tick();
    tick();
    start_pkt(64'h200, 1'b1, 1'b0);
    wait_idle(50);
    check("pkt_after_reset", 64'(rpt_pkt), 64'd1);

    // packet counter wraps to zero
    n_wrap = (1 << PW) - int'(exp_pkt);
    for (int p = 0; p < n_wrap; p++) begin
      m = '0;
      if ($urandom_range(0, 3) != 0) m[$urandom_range(0, NE - 1)] = 1'b1;
      start_pkt(m, 1'b1, 1'b0);
      wait_idle(20);
    end
    check("pkt_wrapped", 64'(rpt_pkt), 64'd0);
    start_pkt(64'h4, 1'b1, 1'b0);
    wait_idle(20);
    check("pkt_post_wrap", 64'(rpt_pkt), 64'd1);
    check("drop_final", 64'(drop_cnt), 64'd0);

    tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
